control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-003 SHALL have port IR_Data, input, 32, current instruction; opcode IR[31:27].
REQ-004 SHALL have port CON_out, input, 1, branch-condition result from CON FF logic.
REQ-005 SHALL have ports PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, output, 1 each, register load strobes.
REQ-006 SHALL have ports PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out, output, 1 each, bus drive strobes.
REQ-007 SHALL have ports Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, output, 1 each, memory and select/encode controls.
REQ-008 SHALL have port alu_instruction_bits, output, 5, ALU operation code; 0 when not computing.
REQ-009 SHALL have port halted, output, 1, high while in HALT.

Function
REQ-010 SHALL be a Moore FSM; states T0..T7 and HALT; each state lasts exactly one clk cycle; outputs are decoded from state and latched opcode only.
REQ-011 SHALL run fetch for every instruction: T0 PC_out,MAR_in,IncPC,Z_in; T1 Zlow_out,PC_in,Read,MDR_in; T2 MDR_out,IR_in.
REQ-012 SHALL decode IR_Data[31:27] in T3 (IR loaded at end of T2); unasserted outputs are 0 in every state.
REQ-013 SHALL sequence add/sub/and/or/ror/rol/shr/shra/shl (00011-01011): T3 Grb,Rout,Y_in; T4 Grc,Rout,Z_in, alu=opcode; T5 Zlow_out,Gra,Rin; then T0.
REQ-014 SHALL sequence addi/andi/ori (01100/01101/01110): T3 Grb,Rout,Y_in; T4 C_out,Z_in, alu=00011/00101/00110 respectively; T5 Zlow_out,Gra,Rin.
REQ-015 SHALL sequence neg/not (10001/10010): T3 Grb,Rout,Z_in, alu=opcode; T4 Zlow_out,Gra,Rin.
REQ-016 SHALL sequence mul/div (01111/10000): T3 Gra,Rout,Y_in; T4 Grb,Rout,Z_in, alu=opcode; T5 Zlow_out,LO_in; T6 Zhigh_out,HI_in.
REQ-017 SHALL sequence ld/ldi/st address phase: T3 Grb,BAout,Y_in; T4 C_out,Z_in, alu=00011; ldi T5 Zlow_out,Gra,Rin.
REQ-018 SHALL finish ld: T5 Zlow_out,MAR_in; T6 Read,MDR_in; T7 MDR_out,Gra,Rin.
REQ-019 SHALL finish st: T5 Zlow_out,MAR_in; T6 Gra,Rout,MDR_in (Read=0); T7 Write.
REQ-020 SHALL sequence br (10011): T3 Gra,Rout, CON_out sampled into internal flag at end of T3; T4 PC_out,Y_in; T5 C_out,Z_in, alu=00011; T6 Zlow_out,PC_in only if flag=1, else no outputs.
REQ-021 SHALL sequence single-step ops in T3: in Gra,Rin,InPort_out; out Gra,Rout,OutPort_in; mfhi HI_out,Gra,Rin; mflo LO_out,Gra,Rin.
REQ-022 SHALL treat nop (11010) and every undefined opcode (incl. jr/jal) as T3 with no outputs, then T0.
REQ-023 SHALL enter HALT from T3 on halt (11011); HALT drives all controls 0, halted=1, and persists until clr.
REQ-024 SHALL return to T0 on the cycle after each sequence's final step; latency in cycles = final step index + 1 (ALU reg 6, ld 8).

Reset
REQ-025 SHALL, when clr is high at a rising edge, set state to T0 and clear branch flag, regardless of current state (mid-instruction or HALT).
REQ-026 SHALL force every control output and halted to 0 combinationally while clr is high.
REQ-027 SHALL begin fetch (T0 outputs) in the first cycle after clr deasserts.

Structure
REQ-028 SHALL take opcode constants, ALU code constants and the state enumeration from shared package cpu_pkg.
REQ-029 SHALL instantiate one sub-module, op_decode, mapping opcode to instruction class and ALU code.

Verification
REQ-030 SHALL test ori: IR 0x71180025 -> T3 Grb,Rout,Y_in; T4 C_out,Z_in, alu=00110; T5 Zlow_out,Gra,Rin; T0 on cycle 7 after fetch start.
REQ-031 SHALL test ld: IR 0x00800055 -> T5 MAR_in, T6 Read,MDR_in, T7 MDR_out,Gra,Rin; no Write at any step.
REQ-032 SHALL test br: IR 0x9A00000A with CON_out=0 -> no PC_in in T6; repeat with CON_out=1 -> Zlow_out,PC_in in T6.
REQ-033 SHALL test halt: IR 0xD8000000 -> halted=1, all controls 0 for 20 cycles; clr pulse -> T0 outputs next cycle.
REQ-034 SHALL test clr asserted during T5 of mul -> no HI_in ever, all outputs 0 during clr, fetch restarts at T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode and ALU code
// constants, the sequencer state enumeration, the instruction classes
// produced by op_decode, and the bundle of control strobes.
package cpu_pkg;

   // Instruction opcodes (IR[31:27])
   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU operation codes driven on alu_instruction_bits
   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_AND  = 5'b00101;
   localparam logic [4:0] ALU_OR   = 5'b00110;

   typedef enum logic [3:0] {
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP,    // nop and every undefined opcode (jr/jal included)
      CLS_ALU3,   // three-register ALU ops
      CLS_IMM,    // addi/andi/ori
      CLS_UNARY,  // neg/not
      CLS_MULDIV, // mul/div, result split into LO/HI
      CLS_LD,
      CLS_LDI,
      CLS_ST,
      CLS_BR,
      CLS_IN,
      CLS_OUT,
      CLS_MFHI,
      CLS_MFLO,
      CLS_HALT
   } cls_t;

   typedef struct packed {
      logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
      logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
      logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
   } ctrl_t;

endpackage

// File: rtl/control_sequencer_op_decode.sv
// op_decode: maps a 5-bit opcode onto the instruction class that steers
// the sequencer, plus the ALU code used in the instruction's compute step.
//   opcode   : instruction opcode
//   cls      : instruction class
//   alu_code : ALU operation for the compute step (0 if none)
module op_decode
   import cpu_pkg::*;
(
   input  logic [4:0] opcode,
   output cls_t       cls,
   output logic [4:0] alu_code
);

   always_comb begin
      cls      = CLS_NOP;
      alu_code = ALU_NONE;
      if (opcode >= OP_ADD && opcode <= OP_SHL) begin
         cls      = CLS_ALU3;
         alu_code = opcode;
      end else begin
         case (opcode)
            OP_ADDI: begin cls = CLS_IMM;    alu_code = ALU_ADD; end
            OP_ANDI: begin cls = CLS_IMM;    alu_code = ALU_AND; end
            OP_ORI:  begin cls = CLS_IMM;    alu_code = ALU_OR;  end
            OP_MUL,
            OP_DIV:  begin cls = CLS_MULDIV; alu_code = opcode;  end
            OP_NEG,
            OP_NOT:  begin cls = CLS_UNARY;  alu_code = opcode;  end
            // memory and branch ops all compute an effective address by adding
            OP_LD:   begin cls = CLS_LD;     alu_code = ALU_ADD; end
            OP_LDI:  begin cls = CLS_LDI;    alu_code = ALU_ADD; end
            OP_ST:   begin cls = CLS_ST;     alu_code = ALU_ADD; end
            OP_BR:   begin cls = CLS_BR;     alu_code = ALU_ADD; end
            OP_IN:   cls = CLS_IN;
            OP_OUT:  cls = CLS_OUT;
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit of the multi-cycle CPU. Every
// instruction runs the T0..T2 fetch, is decoded in T3 and then steps
// through its own T3..T7 sequence before returning to T0; halt parks the
// machine in HALT until clr.
//   clk, clr         : clock, synchronous active-high reset
//   IR_Data, CON_out : current instruction, branch-condition result
//   *_in / IncPC     : register load strobes
//   *_out            : bus drive strobes
//   Read..BAout      : memory and register select/encode controls
//   alu_instruction_bits : ALU op code, 0 outside compute steps
//   halted           : high in HALT
module control_sequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_Data,
   input  logic        CON_out,
   output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
   output logic        OutPort_in, IncPC,
   output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
   output logic        InPort_out, C_out,
   output logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [4:0]  alu_instruction_bits,
   output logic        halted
);

   state_t     state;
   logic [4:0] op_q;     // opcode latched at the end of T3
   logic       br_flag;  // CON_out captured at the end of T3
   logic [4:0] op_cur;
   cls_t       cls;
   logic [4:0] alu_code;
   ctrl_t      c;
   logic [4:0] alu_c;
   logic       halted_c;

   // Only the opcode field matters here.
   logic unused_ir;
   assign unused_ir = ^IR_Data[26:0];

   // IR is loaded at the end of T2, so during T3 the live IR is the only
   // source; afterwards the latched copy keeps the sequence stable even
   // if IR changes.
   assign op_cur = (state == ST_T3) ? IR_Data[31:27] : op_q;

   op_decode u_dec (
      .opcode   (op_cur),
      .cls      (cls),
      .alu_code (alu_code)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= ST_T0;
         br_flag <= 1'b0;
         op_q    <= '0;
      end else begin
         case (state)
            ST_T0: state <= ST_T1;
            ST_T1: state <= ST_T2;
            ST_T2: state <= ST_T3;
            ST_T3: begin
               op_q    <= IR_Data[31:27];
               br_flag <= CON_out;
               case (cls)
                  CLS_ALU3, CLS_IMM, CLS_UNARY, CLS_MULDIV,
                  CLS_LD, CLS_LDI, CLS_ST, CLS_BR: state <= ST_T4;
                  CLS_HALT:                        state <= ST_HALT;
                  default:                         state <= ST_T0;
               endcase
            end
            ST_T4: state <= (cls == CLS_UNARY) ? ST_T0 : ST_T5;
            ST_T5: state <= (cls == CLS_MULDIV || cls == CLS_LD ||
                             cls == CLS_ST || cls == CLS_BR) ? ST_T6 : ST_T0;
            ST_T6: state <= (cls == CLS_LD || cls == CLS_ST) ? ST_T7 : ST_T0;
            ST_T7: state <= ST_T0;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_T0;
         endcase
      end
   end

   always_comb begin
      c        = '0;
      alu_c    = ALU_NONE;
      halted_c = 1'b0;
      case (state)
         ST_T0: begin c.PC_out = 1'b1; c.MAR_in = 1'b1; c.IncPC = 1'b1; c.Z_in = 1'b1; end
         ST_T1: begin c.Zlow_out = 1'b1; c.PC_in = 1'b1; c.Read = 1'b1; c.MDR_in = 1'b1; end
         ST_T2: begin c.MDR_out = 1'b1; c.IR_in = 1'b1; end
         ST_T3: begin
            case (cls)
               CLS_ALU3, CLS_IMM: begin c.Grb = 1'b1; c.Rout = 1'b1; c.Y_in = 1'b1; end
               CLS_UNARY: begin
                  c.Grb = 1'b1; c.Rout = 1'b1; c.Z_in = 1'b1; alu_c = alu_code;
               end
               CLS_MULDIV: begin c.Gra = 1'b1; c.Rout = 1'b1; c.Y_in = 1'b1; end
               CLS_LD, CLS_LDI, CLS_ST: begin c.Grb = 1'b1; c.BAout = 1'b1; c.Y_in = 1'b1; end
               CLS_BR:   begin c.Gra = 1'b1; c.Rout = 1'b1; end
               CLS_IN:   begin c.Gra = 1'b1; c.Rin = 1'b1; c.InPort_out = 1'b1; end
               CLS_OUT:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutPort_in = 1'b1; end
               CLS_MFHI: begin c.HI_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               CLS_MFLO: begin c.LO_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               default: ;
            endcase
         end
         ST_T4: begin
            case (cls)
               CLS_ALU3: begin
                  c.Grc = 1'b1; c.Rout = 1'b1; c.Z_in = 1'b1; alu_c = alu_code;
               end
               CLS_IMM, CLS_LD, CLS_LDI, CLS_ST: begin
                  c.C_out = 1'b1; c.Z_in = 1'b1; alu_c = alu_code;
               end
               CLS_UNARY: begin c.Zlow_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               CLS_MULDIV: begin
                  c.Grb = 1'b1; c.Rout = 1'b1; c.Z_in = 1'b1; alu_c = alu_code;
               end
               CLS_BR: begin c.PC_out = 1'b1; c.Y_in = 1'b1; end
               default: ;
            endcase
         end
         ST_T5: begin
            case (cls)
               CLS_ALU3, CLS_IMM, CLS_LDI: begin
                  c.Zlow_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
               end
               CLS_MULDIV:     begin c.Zlow_out = 1'b1; c.LO_in = 1'b1; end
               CLS_LD, CLS_ST: begin c.Zlow_out = 1'b1; c.MAR_in = 1'b1; end
               CLS_BR: begin c.C_out = 1'b1; c.Z_in = 1'b1; alu_c = alu_code; end
               default: ;
            endcase
         end
         ST_T6: begin
            case (cls)
               CLS_MULDIV: begin c.Zhigh_out = 1'b1; c.HI_in = 1'b1; end
               CLS_LD:     begin c.Read = 1'b1; c.MDR_in = 1'b1; end
               CLS_ST:     begin c.Gra = 1'b1; c.Rout = 1'b1; c.MDR_in = 1'b1; end
               CLS_BR: begin
                  // branch target is written back only when the condition held
                  c.Zlow_out = br_flag; c.PC_in = br_flag;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (cls)
               CLS_LD: begin c.MDR_out = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
               CLS_ST: c.Write = 1'b1;
               default: ;
            endcase
         end
         ST_HALT: halted_c = 1'b1;
         default: ;
      endcase
      // clr silences everything immediately, not just from the next edge
      if (clr) begin
         c        = '0;
         alu_c    = ALU_NONE;
         halted_c = 1'b0;
      end
   end

   assign PC_in      = c.PC_in;
   assign IR_in      = c.IR_in;
   assign Y_in       = c.Y_in;
   assign Z_in       = c.Z_in;
   assign HI_in      = c.HI_in;
   assign LO_in      = c.LO_in;
   assign MAR_in     = c.MAR_in;
   assign MDR_in     = c.MDR_in;
   assign OutPort_in = c.OutPort_in;
   assign IncPC      = c.IncPC;
   assign PC_out     = c.PC_out;
   assign Zhigh_out  = c.Zhigh_out;
   assign Zlow_out   = c.Zlow_out;
   assign HI_out     = c.HI_out;
   assign LO_out     = c.LO_out;
   assign MDR_out    = c.MDR_out;
   assign InPort_out = c.InPort_out;
   assign C_out      = c.C_out;
   assign Read       = c.Read;
   assign Write      = c.Write;
   assign Gra        = c.Gra;
   assign Grb        = c.Grb;
   assign Grc        = c.Grc;
   assign Rin        = c.Rin;
   assign Rout       = c.Rout;
   assign BAout      = c.BAout;
   assign alu_instruction_bits = alu_c;
   assign halted     = halted_c;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table of instructions with
// their expected per-step control words, fed through a scoreboard queue,
// plus hand-written halt and clr-abort sequences.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] IR_Data = '0;
   logic        CON_out = 1'b0;
   logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
   logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
   logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, halted;
   logic [4:0] alu_instruction_bits;

   control_sequencer dut (
      .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out),
      .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in),
      .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in),
      .IncPC(IncPC), .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out),
      .HI_out(HI_out), .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out),
      .C_out(C_out), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .alu_instruction_bits(alu_instruction_bits), .halted(halted)
   );

   always #5 clk = ~clk;

   // Observed control word: alu in [31:27], halted at 26, strobes below.
   localparam logic [31:0] PCIN  = 32'd1 << 0,  IRIN  = 32'd1 << 1,  YIN   = 32'd1 << 2;
   localparam logic [31:0] ZIN   = 32'd1 << 3,  HIIN  = 32'd1 << 4,  LOIN  = 32'd1 << 5;
   localparam logic [31:0] MARIN = 32'd1 << 6,  MDRIN = 32'd1 << 7,  OPIN  = 32'd1 << 8;
   localparam logic [31:0] INCPC = 32'd1 << 9,  PCOUT = 32'd1 << 10, ZHI   = 32'd1 << 11;
   localparam logic [31:0] ZLO   = 32'd1 << 12, HIOUT = 32'd1 << 13, LOOUT = 32'd1 << 14;
   localparam logic [31:0] MDROUT= 32'd1 << 15, INPRT = 32'd1 << 16, COUT  = 32'd1 << 17;
   localparam logic [31:0] RD    = 32'd1 << 18, WR    = 32'd1 << 19, GRA   = 32'd1 << 20;
   localparam logic [31:0] GRB   = 32'd1 << 21, GRC   = 32'd1 << 22, RIN   = 32'd1 << 23;
   localparam logic [31:0] ROUT  = 32'd1 << 24, BAO   = 32'd1 << 25, HALT  = 32'd1 << 26;
   localparam logic [31:0] F0 = PCOUT | MARIN | INCPC | ZIN;
   localparam logic [31:0] F1 = ZLO | PCIN | RD | MDRIN;
   localparam logic [31:0] F2 = MDROUT | IRIN;

   function automatic logic [31:0] alu(input logic [4:0] a);
      return {a, 27'd0};
   endfunction

   logic [31:0] obs;
   assign obs = {alu_instruction_bits, halted, BAout, Rout, Rin, Grc, Grb, Gra, Write,
                 Read, C_out, InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out,
                 PC_out, IncPC, OutPort_in, MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in,
                 IR_in, PC_in};

   int checks = 0;
   int failures = 0;
   logic [31:0] sb[$];

   task automatic chk(input string nm, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, obs, exp);
      end
   endtask

   // Hold clr for two edges (checking outputs are silent), release on a negedge.
   task automatic do_reset(input string nm);
      @(negedge clk);
      clr = 1'b1;
      #1 chk({nm, "_clr0"}, 32'd0);
      @(negedge clk);
      #1 chk({nm, "_clr1"}, 32'd0);
      clr = 1'b0;
   endtask

   typedef struct {
      string       nm;
      logic [31:0] ir;
      logic        con;
      int          n;        // number of steps from T3 on
      logic [31:0] st[5];
   } vec_t;

   vec_t vt[18];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{"add",  32'h1811_8000, 1'b0, 3, '{GRB|ROUT|YIN, GRC|ROUT|ZIN|alu(5'b00011), ZLO|GRA|RIN, 0, 0}};
      vt[1]  = '{"shl",  32'h5800_0000, 1'b0, 3, '{GRB|ROUT|YIN, GRC|ROUT|ZIN|alu(5'b01011), ZLO|GRA|RIN, 0, 0}};
      vt[2]  = '{"ori",  32'h7118_0025, 1'b0, 3, '{GRB|ROUT|YIN, COUT|ZIN|alu(5'b00110), ZLO|GRA|RIN, 0, 0}};
      vt[3]  = '{"addi", 32'h6000_0001, 1'b0, 3, '{GRB|ROUT|YIN, COUT|ZIN|alu(5'b00011), ZLO|GRA|RIN, 0, 0}};
      vt[4]  = '{"andi", 32'h6800_0001, 1'b0, 3, '{GRB|ROUT|YIN, COUT|ZIN|alu(5'b00101), ZLO|GRA|RIN, 0, 0}};
      vt[5]  = '{"neg",  32'h8800_0000, 1'b0, 2, '{GRB|ROUT|ZIN|alu(5'b10001), ZLO|GRA|RIN, 0, 0, 0}};
      vt[6]  = '{"div",  32'h8000_0000, 1'b0, 4, '{GRA|ROUT|YIN, GRB|ROUT|ZIN|alu(5'b10000), ZLO|LOIN, ZHI|HIIN, 0}};
      vt[7]  = '{"ld",   32'h0080_0055, 1'b0, 5, '{GRB|BAO|YIN, COUT|ZIN|alu(5'b00011), ZLO|MARIN, RD|MDRIN, MDROUT|GRA|RIN}};
      vt[8]  = '{"ldi",  32'h0800_0010, 1'b0, 3, '{GRB|BAO|YIN, COUT|ZIN|alu(5'b00011), ZLO|GRA|RIN, 0, 0}};
      vt[9]  = '{"st",   32'h1000_0010, 1'b0, 5, '{GRB|BAO|YIN, COUT|ZIN|alu(5'b00011), ZLO|MARIN, GRA|ROUT|MDRIN, WR}};
      vt[10] = '{"br0",  32'h9A00_000A, 1'b0, 4, '{GRA|ROUT, PCOUT|YIN, COUT|ZIN|alu(5'b00011), 32'd0, 0}};
      vt[11] = '{"br1",  32'h9A00_000A, 1'b1, 4, '{GRA|ROUT, PCOUT|YIN, COUT|ZIN|alu(5'b00011), ZLO|PCIN, 0}};
      vt[12] = '{"in",   32'hB000_0000, 1'b0, 1, '{GRA|RIN|INPRT, 0, 0, 0, 0}};
      vt[13] = '{"out",  32'hB800_0000, 1'b0, 1, '{GRA|ROUT|OPIN, 0, 0, 0, 0}};
      vt[14] = '{"mfhi", 32'hC000_0000, 1'b0, 1, '{HIOUT|GRA|RIN, 0, 0, 0, 0}};
      vt[15] = '{"mflo", 32'hC800_0000, 1'b0, 1, '{LOOUT|GRA|RIN, 0, 0, 0, 0}};
      vt[16] = '{"nop",  32'hD000_0000, 1'b0, 1, '{32'd0, 0, 0, 0, 0}};
      vt[17] = '{"jr",   32'hA000_0000, 1'b0, 1, '{32'd0, 0, 0, 0, 0}};

      // Table: fetch, instruction steps, then the following T0.
      foreach (vt[v]) begin
         IR_Data = vt[v].ir;
         do_reset(vt[v].nm);
         sb.push_back(F0); sb.push_back(F1); sb.push_back(F2);
         for (int s = 0; s < vt[v].n; s++) sb.push_back(vt[v].st[s]);
         sb.push_back(F0);
         for (int k = 0; sb.size() > 0; k++) begin
            // CON_out carries the wanted value only in T3, the opposite
            // elsewhere, so the sample point matters.
            CON_out = (k == 3) ? vt[v].con : ~vt[v].con;
            #1 chk($sformatf("%s_step%0d", vt[v].nm, k), sb.pop_front());
            @(negedge clk);
         end
      end

      // halt: parks with halted=1 until clr, then fetch resumes at once.
      IR_Data = 32'hD800_0000;
      do_reset("halt");
      #1 chk("halt_T0", F0); @(negedge clk);
      #1 chk("halt_T1", F1); @(negedge clk);
      #1 chk("halt_T2", F2); @(negedge clk);
      #1 chk("halt_T3", 32'd0); @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         #1 chk($sformatf("halt_hold%0d", i), HALT);
         @(negedge clk);
      end
      IR_Data = 32'hD000_0000;
      clr = 1'b1;
      #1 chk("halt_clr", 32'd0);
      @(negedge clk);
      clr = 1'b0;
      #1 chk("halt_rel_T0", F0); @(negedge clk);
      #1 chk("halt_rel_T1", F1); @(negedge clk);

      // mul aborted by clr in T5: HI step never happens.
      IR_Data = 32'h7800_0000;
      do_reset("mul");
      #1 chk("mul_T0", F0); @(negedge clk);
      #1 chk("mul_T1", F1); @(negedge clk);
      #1 chk("mul_T2", F2); @(negedge clk);
      #1 chk("mul_T3", GRA|ROUT|YIN); @(negedge clk);
      #1 chk("mul_T4", GRB|ROUT|ZIN|alu(5'b01111)); @(negedge clk);
      #1 chk("mul_T5", ZLO|LOIN);
      clr = 1'b1;
      #1 chk("mul_clr_T5", 32'd0);
      IR_Data = 32'hD000_0000;
      @(negedge clk);
      #1 chk("mul_clr_next", 32'd0);
      clr = 1'b0;
      #1 chk("mul_re_T0", F0); @(negedge clk);
      #1 chk("mul_re_T1", F1); @(negedge clk);
      #1 chk("mul_re_T2", F2); @(negedge clk);
      #1 chk("mul_re_T3", 32'd0); @(negedge clk);
      #1 chk("mul_re_T0b", F0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
